alu_stim_seq: RTL and testbench

- Parametrised ALU stimulus sequencer and response compactor for the DLX ALU verification environment.
- Generates operand pairs from an LFSR and sweeps opcodes round-robin.
- Drives each transaction with a valid/ready handshake and folds returned ALU results into a MISR signature.
- Sits between the bench's clock/reset source and the ALU DUT, so long regressions run without a software driver.

---
 rtl/alu_stim_seq.sv | 168 ++++++++++++++++
 tb/tb_alu_stim_seq.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_stim_seq.sv
// ALU stimulus sequencer: LFSR operands, round-robin opcodes, MISR-compacted responses.
// Define ALU_STIM_CORNER_EN to prefix each run with four fixed corner operand pairs.
module alu_stim_seq #(
  parameter int unsigned       NBIT      = 8,
  parameter int unsigned       NOP       = 4,
  parameter int unsigned       OPW       = 2,
  parameter int unsigned       CNTW      = 16,
  parameter logic [2*NBIT-1:0] LFSR_POLY = 'h002D,
  parameter logic [NBIT-1:0]   MISR_POLY = 'h1D
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2*NBIT-1:0] seed,
  input  logic [CNTW-1:0]   num_txn,
  output logic              stim_valid,
  input  logic              stim_ready,
  output logic [OPW-1:0]    alu_op,
  output logic [NBIT-1:0]   alu_in_a,
  output logic [NBIT-1:0]   alu_in_b,
  input  logic              rsp_valid,
  input  logic [NBIT-1:0]   rsp_data,
  output logic              busy,
  output logic              done,
  output logic [NBIT-1:0]   signature,
  output logic              rsp_err
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e            state_q, state_d;
  logic [2*NBIT-1:0] lfsr_q, lfsr_d;
  logic [OPW-1:0]    op_q, op_d;
  logic [CNTW-1:0]   issued_q, issued_d;
  logic [CNTW-1:0]   received_q, received_d;
  logic [CNTW-1:0]   num_q, num_d;
  logic [NBIT-1:0]   sig_q, sig_d;
  logic              err_q, err_d;

  logic              run;
  logic              xfer;
  logic              rsp_active;
  logic [CNTW-1:0]   issued_eff;
  logic              corner_phase;
  logic [NBIT-1:0]   corner_a, corner_b;

`ifdef ALU_STIM_CORNER_EN
  // Corner pairs are indexed by the issue count, so the LFSR holds still until txn 4.
  assign corner_phase = (issued_q < CNTW'(4));

  always_comb begin
    corner_a = '0;
    corner_b = '0;
    unique case (issued_q[1:0])
      2'd0: begin
        corner_a = '0;
        corner_b = '0;
      end
      2'd1: begin
        corner_a = '1;
        corner_b = '1;
      end
      2'd2: begin
        corner_a = {1'b1, {(NBIT-1){1'b0}}};
        corner_b = NBIT'(1);
      end
      2'd3: begin
        corner_a = NBIT'(1);
        corner_b = {1'b1, {(NBIT-1){1'b0}}};
      end
    endcase
  end
`else
  assign corner_phase = 1'b0;
  assign corner_a     = '0;
  assign corner_b     = '0;
`endif

  assign run        = (state_q == StRun);
  assign xfer       = run && stim_ready;
  assign rsp_active = (state_q == StRun) || (state_q == StDrain);
  // A zero-latency DUT may answer the stimulus being transferred this very cycle.
  assign issued_eff = issued_q + {{(CNTW-1){1'b0}}, xfer};

  assign stim_valid = run;
  assign alu_op     = run ? op_q : '0;
  assign alu_in_a   = !run ? '0 : (corner_phase ? corner_a : lfsr_q[2*NBIT-1:NBIT]);
  assign alu_in_b   = !run ? '0 : (corner_phase ? corner_b : lfsr_q[NBIT-1:0]);
  assign busy       = rsp_active;
  assign done       = (state_q == StDone);
  assign signature  = sig_q;
  assign rsp_err    = err_q;

  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    op_d       = op_q;
    issued_d   = issued_q;
    received_d = received_q;
    num_d      = num_q;
    sig_d      = sig_q;
    err_d      = err_q;

    if (rsp_active && rsp_valid) begin
      if (received_q < issued_eff) begin
        received_d = received_q + CNTW'(1);
        sig_d      = {sig_q[NBIT-2:0], 1'b0} ^ (sig_q[NBIT-1] ? MISR_POLY : '0) ^ rsp_data;
      end else begin
        err_d = 1'b1;
      end
    end

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          num_d      = num_txn;
          lfsr_d     = (seed == '0) ? (2*NBIT)'(1) : seed;
          op_d       = '0;
          issued_d   = '0;
          received_d = '0;
          sig_d      = '0;
          err_d      = 1'b0;
          state_d    = (num_txn == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (xfer) begin
          issued_d = issued_q + CNTW'(1);
          if (!corner_phase) begin
            lfsr_d = {lfsr_q[2*NBIT-2:0], 1'b0} ^ (lfsr_q[2*NBIT-1] ? LFSR_POLY : '0);
          end
          op_d = (op_q == OPW'(NOP - 1)) ? '0 : op_q + OPW'(1);
          if (issued_d == num_q) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (received_d == issued_q) begin
          state_d = StDone;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      lfsr_q     <= '0;
      op_q       <= '0;
      issued_q   <= '0;
      received_q <= '0;
      num_q      <= '0;
      sig_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      op_q       <= op_d;
      issued_q   <= issued_d;
      received_q <= received_d;
      num_q      <= num_d;
      sig_q      <= sig_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_alu_stim_seq.sv
// Directed bench for alu_stim_seq (NBIT=8, NOP=4); expected values are hand-derived.
// Honours ALU_STIM_CORNER_EN to select the matching expected operand tables.
module tb_alu_stim_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] seed = '0;
  logic [15:0] num_txn = '0;
  logic        stim_valid;
  logic        stim_ready = 1'b0;
  logic [1:0]  alu_op;
  logic [7:0]  alu_in_a;
  logic [7:0]  alu_in_b;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        busy;
  logic        done;
  logic [7:0]  signature;
  logic        rsp_err;

  logic        auto_rsp = 1'b1;
  logic        man_valid = 1'b0;
  logic [7:0]  man_data = '0;

  int tests = 0;
  int fails = 0;

  logic [7:0] exp_a [6];
  logic [7:0] exp_b [6];
  logic [7:0] exp_sig;
  logic [7:0] exp_sig2;
  int         corner_n;

  // Auto mode emulates a zero-latency ALU that returns operand A.
  assign rsp_valid = auto_rsp ? (stim_valid && stim_ready) : man_valid;
  assign rsp_data  = auto_rsp ? alu_in_a : man_data;

  always #5 clk = ~clk;

  alu_stim_seq #(
    .NBIT(8),
    .NOP(4),
    .OPW(2),
    .CNTW(16),
    .LFSR_POLY(16'h002D),
    .MISR_POLY(8'h1D)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .seed(seed),
    .num_txn(num_txn),
    .stim_valid(stim_valid),
    .stim_ready(stim_ready),
    .alu_op(alu_op),
    .alu_in_a(alu_in_a),
    .alu_in_b(alu_in_b),
    .rsp_valid(rsp_valid),
    .rsp_data(rsp_data),
    .busy(busy),
    .done(done),
    .signature(signature),
    .rsp_err(rsp_err)
  );

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    tests++;
    if ({stim_valid, busy, done, rsp_err} !== 4'b0) begin
      fails++;
      $display("FAIL reset_flags got=%b want=0000", {stim_valid, busy, done, rsp_err});
    end
    tests++;
    if ({alu_op, alu_in_a, alu_in_b, signature} !== 26'h0) begin
      fails++;
      $display("FAIL reset_data got op=%0d a=%h b=%h sig=%h want all 0",
               alu_op, alu_in_a, alu_in_b, signature);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Six-transaction run from seed 0xACE1; optional 3-cycle stall on the 2nd transaction
  // plus a start pulse mid-run that must be ignored.
  task automatic test_run(input bit stall);
    int idx = 0;
    int nvalid = 0;
    int nbusy = 0;
    int stalls = 0;
    int cyc = 0;
    auto_rsp   = 1'b1;
    stim_ready = 1'b1;
    seed       = 16'hACE1;
    num_txn    = 16'd6;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!done && cyc < 60) begin
      stim_ready = !(stall && idx == 1 && stalls < 3);
      if (!stim_ready) stalls++;
      start   = stall && idx == 3;
      num_txn = (stall && idx == 3) ? 16'd2 : 16'd6;
      if (busy) nbusy++;
      if (stim_valid) begin
        nvalid++;
        tests++;
        if (idx > 5) begin
          fails++;
          $display("FAIL run_extra_stim got idx=%0d want <=5", idx);
        end else if (alu_op !== 2'(idx % 4) || alu_in_a !== exp_a[idx] ||
                     alu_in_b !== exp_b[idx]) begin
          fails++;
          $display("FAIL run_stim idx=%0d got op=%0d a=%h b=%h want op=%0d a=%h b=%h",
                   idx, alu_op, alu_in_a, alu_in_b, idx % 4, exp_a[idx], exp_b[idx]);
        end
        if (stim_ready) idx++;
      end
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL run_timeout got done=%b want 1", done);
    end
    tests++;
    if (idx != 6) begin
      fails++;
      $display("FAIL run_transfers got=%0d want=6", idx);
    end
    tests++;
    if (nvalid != (stall ? 9 : 6) || nbusy != (stall ? 10 : 7)) begin
      fails++;
      $display("FAIL run_cycles got valid=%0d busy=%0d want valid=%0d busy=%0d",
               nvalid, nbusy, stall ? 9 : 6, stall ? 10 : 7);
    end
    tests++;
    if (signature !== exp_sig || rsp_err !== 1'b0) begin
      fails++;
      $display("FAIL run_signature got sig=%h err=%b want sig=%h err=0",
               signature, rsp_err, exp_sig);
    end
  endtask

  task automatic test_zero();
    seed    = 16'hACE1;
    num_txn = 16'd0;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tests++;
    if ({done, busy, stim_valid} !== 3'b100 || signature !== 8'h00) begin
      fails++;
      $display("FAIL zero_txn got done=%b busy=%b valid=%b sig=%h want 1 0 0 00",
               done, busy, stim_valid, signature);
    end
    @(negedge clk);
    tests++;
    if (stim_valid !== 1'b0 || done !== 1'b1) begin
      fails++;
      $display("FAIL zero_txn_hold got valid=%b done=%b want 0 1", stim_valid, done);
    end
  endtask

  task automatic test_rsp_err();
    auto_rsp   = 1'b0;
    stim_ready = 1'b1;
    seed       = 16'hACE1;
    num_txn    = 16'd2;
    start      = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    man_valid = 1'b1;
    man_data  = 8'h01;
    @(negedge clk);
    tests++;
    if (signature !== 8'h01) begin
      fails++;
      $display("FAIL rsp_first got sig=%h want 01", signature);
    end
    man_data = 8'h02;
    @(negedge clk);
    tests++;
    if (signature !== 8'h00 || stim_valid !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL rsp_second got sig=%h valid=%b busy=%b want 00 0 1",
               signature, stim_valid, busy);
    end
    man_data = 8'h55;
    @(negedge clk);
    man_valid = 1'b0;
    tests++;
    if (rsp_err !== 1'b1 || signature !== 8'h00 || done !== 1'b1) begin
      fails++;
      $display("FAIL rsp_extra got err=%b sig=%h done=%b want 1 00 1",
               rsp_err, signature, done);
    end
  endtask

  task automatic test_misr_feedback();
    auto_rsp   = 1'b0;
    stim_ready = 1'b1;
    num_txn    = 16'd2;
    start      = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    man_valid = 1'b1;
    man_data  = 8'h80;
    tests++;
    if (rsp_err !== 1'b0) begin
      fails++;
      $display("FAIL misr_err_clear got err=%b want 0", rsp_err);
    end
    @(negedge clk);
    tests++;
    if (signature !== 8'h80) begin
      fails++;
      $display("FAIL misr_first got sig=%h want 80", signature);
    end
    man_data = 8'h00;
    @(negedge clk);
    man_valid = 1'b0;
    tests++;
    if (signature !== 8'h1D) begin
      fails++;
      $display("FAIL misr_feedback got sig=%h want 1d", signature);
    end
    @(negedge clk);
    man_valid = 1'b1;
    man_data  = 8'hFF;
    @(negedge clk);
    man_valid = 1'b0;
    tests++;
    if (signature !== 8'h1D || rsp_err !== 1'b0 || done !== 1'b1) begin
      fails++;
      $display("FAIL misr_done_ignore got sig=%h err=%b done=%b want 1d 0 1",
               signature, rsp_err, done);
    end
    auto_rsp = 1'b1;
  endtask

  task automatic test_reset_midrun();
    int idx = 0;
    int cyc = 0;
    auto_rsp   = 1'b1;
    stim_ready = 1'b1;
    seed       = 16'hACE1;
    num_txn    = 16'd6;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (signature !== exp_sig2) begin
      fails++;
      $display("FAIL midrun_partial_sig got=%h want=%h", signature, exp_sig2);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({stim_valid, busy, done} !== 3'b000 || signature !== 8'h00 || alu_in_a !== 8'h00) begin
      fails++;
      $display("FAIL midrun_reset got valid=%b busy=%b done=%b sig=%h a=%h want 0 0 0 00 00",
               stim_valid, busy, done, signature, alu_in_a);
    end
    @(negedge clk);
    rst_n   = 1'b1;
    @(negedge clk);
    seed    = 16'h0000;
    num_txn = 16'd5;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!done && cyc < 40) begin
      if (stim_valid) begin
        if (idx == corner_n) begin
          tests++;
          if (alu_in_a !== 8'h00 || alu_in_b !== 8'h01) begin
            fails++;
            $display("FAIL seed_zero got a=%h b=%h want a=00 b=01", alu_in_a, alu_in_b);
          end
        end
        idx++;
      end
      cyc++;
      @(negedge clk);
    end
    tests++;
    if (idx != 5 || !done) begin
      fails++;
      $display("FAIL seed_zero_run got transfers=%0d done=%b want 5 1", idx, done);
    end
  endtask

`ifdef ALU_STIM_CORNER_EN
  task automatic test_corner_short();
    int idx = 0;
    int cyc = 0;
    auto_rsp   = 1'b1;
    stim_ready = 1'b1;
    seed       = 16'hACE1;
    num_txn    = 16'd2;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!done && cyc < 20) begin
      if (stim_valid) begin
        tests++;
        if (idx > 1 || alu_in_a !== exp_a[idx] || alu_in_b !== exp_b[idx]) begin
          fails++;
          $display("FAIL corner_short idx=%0d got a=%h b=%h", idx, alu_in_a, alu_in_b);
        end
        idx++;
      end
      cyc++;
      @(negedge clk);
    end
    tests++;
    if (idx != 2 || !done) begin
      fails++;
      $display("FAIL corner_short_count got=%0d done=%b want 2 1", idx, done);
    end
  endtask
`endif

  initial begin
`ifdef ALU_STIM_CORNER_EN
    exp_a    = '{8'h00, 8'hFF, 8'h80, 8'h01, 8'hAC, 8'h59};
    exp_b    = '{8'h00, 8'hFF, 8'h01, 8'h80, 8'hE1, 8'hEF};
    exp_sig  = 8'h27;
    exp_sig2 = 8'hFF;
    corner_n = 4;
`else
    exp_a    = '{8'hAC, 8'h59, 8'hB3, 8'h67, 8'hCF, 8'h9E};
    exp_b    = '{8'hE1, 8'hEF, 8'hDE, 8'h91, 8'h22, 8'h69};
    exp_sig  = 8'hB0;
    exp_sig2 = 8'h1C;
    corner_n = 0;
`endif
    test_reset();
    test_run(1'b0);
    test_run(1'b1);
    test_zero();
    test_rsp_err();
    test_misr_feedback();
    test_reset_midrun();
`ifdef ALU_STIM_CORNER_EN
    test_corner_short();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
